debug_button_conditioner: RTL and testbench
===========================================

// Module: debug_button_conditioner
// PURPOSE
//  Conditions the four raw push-buttons that drive the on-screen debug overlay. It produces the
//  per-frame BUTTON_EN strobe and the TOOL_B / PROBE_B event bits consumed by the debug overlay
//  renderer. Raw inputs are synchronised, debounced at frame rate and edge-detected, with auto-repeat.
//  Sits directly upstream of the overlay renderer, between board button pins and the overlay.
// PARAMETERS
//  DEBOUNCE_FRAMES  3   consecutive frame samples that must agree before the debounced level changes
//  REPEAT_DELAY     30  frames from press event to first auto-repeat event
//  REPEAT_RATE      6   frames between subsequent auto-repeat events
// PORTS
//  CLK           in   1  system clock (single clock domain)
//  RESET         in   1  synchronous, active-high reset
//  FRAME_STROBE  in   1  one-cycle pulse per video frame (from video timing)
//  BTN_RAW       in   4  asynchronous raw buttons, active-high; [0]=tool next, [1]=tool prev,
//                        [2]=probe inc, [3]=probe dec
//  BUTTON_EN     out  1  one-cycle pulse, once per frame
//  TOOL_B        out  2  {prev,next} events, valid only while BUTTON_EN=1, else 2'b00
//  PROBE_B       out  2  {dec,inc} events, valid only while BUTTON_EN=1, else 2'b00
// BEHAVIOUR
//  - Reset values: BUTTON_EN=0, TOOL_B=0, PROBE_B=0.
//    All synchroniser flops, debounced levels, debounce counters and repeat counters clear to 0.
//  - Synchroniser: BTN_RAW passes through a 2-flop synchroniser. The sample taken is the synchroniser
//    output in the cycle where FRAME_STROBE=1. No state changes on non-strobe cycles.
//  - Debounce, per button, on each strobe:
//    - sample == debounced level: counter cleared.
//    - sample differs: counter increments. When it reaches DEBOUNCE_FRAMES, the debounced level flips
//      and the counter clears.
//    - Counter width is clog2(DEBOUNCE_FRAMES+1).
//  - Press event: fires on the strobe where the debounced level goes 0->1.
//    - The repeat counter loads REPEAT_DELAY.
//    - A release (1->0) produces no event and clears the repeat counter.
//  - Auto-repeat: while the debounced level is 1, the repeat counter decrements each strobe.
//    - On the strobe where it reaches 0, a repeat event fires and the counter reloads REPEAT_RATE.
//    - Events therefore fire at press strobe k, then k+REPEAT_DELAY, then every REPEAT_RATE strobes.
//    - The counter never wraps below 0.
//  - Output timing: BUTTON_EN=1 in the cycle after every FRAME_STROBE, whether or not events exist
//    (the overlay needs it to initialise its selection). Event bits from that strobe are presented in
//    the same cycle. All outputs are registered, and every output is 0 in all other cycles.
//  - Opposing pair conflict: if next and prev (or inc and dec) both have an event on the same strobe,
//    that pair outputs 2'b00. The other pair is unaffected.
//  - FRAME_STROBE on consecutive cycles is legal; each strobe is processed independently.
//  - RESET mid-operation: outputs read 0 in the cycle after RESET is sampled high, and pending events
//    are dropped. A button held through reset re-debounces from level 0 and yields a fresh press
//    event after DEBOUNCE_FRAMES strobes.
// TESTING
//  Default parameters throughout.
//  1. Reset, then a single FRAME_STROBE, no buttons
//     -> BUTTON_EN pulses 1 cycle after strobe with TOOL_B=00, PROBE_B=00; all outputs 0 otherwise.
//  2. BTN_RAW[0] alternates 1/0 across 5 strobes, then held 1
//     -> exactly one TOOL_B=01 pulse, on the BUTTON_EN following the 3rd consecutive high strobe.
//  3. BTN_RAW[2] held for 50 strobes, debounce completes at strobe 3
//     -> PROBE_B=01 at strobes 3, 33, 39, 45 only.
//  4. BTN_RAW[0] and [1] rise together, BTN_RAW[3] rises at the same time
//     -> on the debounce-complete strobe, TOOL_B=00 and PROBE_B=10.
//  5. RESET pulsed at strobe 20 of a held BTN_RAW[2] press
//     -> outputs 0 next cycle; next press event 3 strobes after reset release; no repeat before +30.
//  6. Held button released
//     -> no event on release; level drops after 3 low strobes; no further repeats.

Source files
------------

// File: rtl/debug_button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : debug_button_conditioner_if
// Description : Groups the frame strobe, raw buttons and overlay event outputs
//               of the debug button conditioner.
//               FRAME_STROBE : one-cycle pulse per video frame
//               BTN_RAW[3:0] : raw asynchronous buttons
//                              [0] tool next, [1] tool prev,
//                              [2] probe inc, [3] probe dec
//               BUTTON_EN    : one-cycle pulse following every frame strobe
//               TOOL_B[1:0]  : {prev,next} events, qualified by BUTTON_EN
//               PROBE_B[1:0] : {dec,inc} events, qualified by BUTTON_EN
//               The master modport drives the strobe and buttons. The slave
//               modport is the conditioner, and it drives the events.
// Revision    : 1.0 - initial release
// ============================================================================
interface debug_button_conditioner_if;
    logic       FRAME_STROBE;
    logic [3:0] BTN_RAW;
    logic       BUTTON_EN;
    logic [1:0] TOOL_B;
    logic [1:0] PROBE_B;

    modport master (
        output FRAME_STROBE,
        output BTN_RAW,
        input  BUTTON_EN,
        input  TOOL_B,
        input  PROBE_B
    );

    modport slave (
        input  FRAME_STROBE,
        input  BTN_RAW,
        output BUTTON_EN,
        output TOOL_B,
        output PROBE_B
    );
endinterface
`default_nettype wire

// File: rtl/debug_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : debug_button_conditioner
// Description : The buttons are synchronised with two flops. They are then
//               debounced at frame rate, and edge-detected with auto-repeat.
//               Once per frame the block presents a BUTTON_EN strobe with the
//               tool and probe event bits for the debug overlay renderer.
//               Ports : CLK, RESET (synchronous, active-high)
//                       bus    (slave modport of debug_button_conditioner_if)
// Revision    : 1.0 - initial release
// ============================================================================
module debug_button_conditioner #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 6
) (
    input  wire logic                 CLK,
    input  wire logic                 RESET,
    debug_button_conditioner_if.slave bus
);

    localparam int c_DB_W    = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [c_DB_W-1:0]  c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_REP_W-1:0] c_REP_DELAY = c_REP_W'(REPEAT_DELAY);
    localparam logic [c_REP_W-1:0] c_REP_RATE  = c_REP_W'(REPEAT_RATE);
    localparam logic [c_REP_W-1:0] c_REP_ONE   = c_REP_W'(1);

    logic [3:0]              sync1_q, sync2_q;
    logic [3:0]              level_q, level_d;
    logic [3:0][c_DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0][c_REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic                    button_en_q, button_en_d;
    logic [1:0]              tool_b_q, tool_b_d;
    logic [1:0]              probe_b_q, probe_b_d;

    logic [3:0]              w_new_level;
    logic [3:0]              w_evt;

    always_comb begin
        level_d     = level_q;
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        w_new_level = level_q;
        w_evt       = '0;
        button_en_d = 1'b0;
        tool_b_d    = 2'b00;
        probe_b_d   = 2'b00;

        if (bus.FRAME_STROBE) begin
            button_en_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
                // Debounce. The level flips only after DEBOUNCE_FRAMES disagreeing samples in a row.
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == c_DB_LAST) begin
                    db_cnt_d[i]    = '0;
                    w_new_level[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + c_DB_ONE;
                end
                level_d[i] = w_new_level[i];

                // Press, release and auto-repeat work on the debounced level.
                // Auto-repeat keeps running while a release is still debouncing.
                if (w_new_level[i] && !level_q[i]) begin
                    w_evt[i]     = 1'b1;
                    rep_cnt_d[i] = c_REP_DELAY;
                end else if (!w_new_level[i]) begin
                    rep_cnt_d[i] = '0;
                end else if (rep_cnt_q[i] == c_REP_ONE) begin
                    w_evt[i]     = 1'b1;
                    rep_cnt_d[i] = c_REP_RATE;
                end else if (rep_cnt_q[i] != '0) begin
                    rep_cnt_d[i] = rep_cnt_q[i] - c_REP_ONE;
                end
            end

            // When both buttons of an opposing pair have an event, they cancel.
            tool_b_d  = (w_evt[0] && w_evt[1]) ? 2'b00 : {w_evt[1], w_evt[0]};
            probe_b_d = (w_evt[2] && w_evt[3]) ? 2'b00 : {w_evt[3], w_evt[2]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            button_en_q <= 1'b0;
            tool_b_q    <= 2'b00;
            probe_b_q   <= 2'b00;
        end else begin
            sync1_q     <= bus.BTN_RAW;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            button_en_q <= button_en_d;
            tool_b_q    <= tool_b_d;
            probe_b_q   <= probe_b_d;
        end
    end

    assign bus.BUTTON_EN = button_en_q;
    assign bus.TOOL_B    = tool_b_q;
    assign bus.PROBE_B   = probe_b_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_button_conditioner
// Description : Directed self-checking bench for debug_button_conditioner.
//               It uses the default parameters. The expected outputs are
//               worked out by hand from the frame-strobe count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_button_conditioner;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   total = 0;
    int   bad   = 0;

    debug_button_conditioner_if bus ();

    debug_button_conditioner dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // The expected value is packed as {BUTTON_EN, TOOL_B, PROBE_B}.
    task automatic check_out(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bus.BUTTON_EN, bus.TOOL_B, bus.PROBE_B};
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Wait two cycles so that the synchroniser holds the current BTN_RAW.
    // Then issue one strobe and check the output cycle that follows it.
    task automatic strobe(input string tag, input logic [1:0] et, input logic [1:0] ep);
        tick();
        tick();
        check_out({tag, "_idle"}, 5'b0_00_00);
        bus.FRAME_STROBE = 1'b1;
        tick();
        bus.FRAME_STROBE = 1'b0;
        check_out(tag, {1'b1, et, ep});
    endtask

    initial begin
        logic [6:0] alt;
        bus.FRAME_STROBE = 1'b0;
        bus.BTN_RAW      = 4'b0000;

        // Reset state
        tick();
        tick();
        check_out("reset", 5'b0_00_00);
        RESET = 1'b0;

        // 1. A single strobe with no buttons pressed
        strobe("t1", 2'b00, 2'b00);
        tick();
        check_out("t1_after", 5'b0_00_00);

        // Back-to-back strobes. BTN[1] debounces in three consecutive cycles.
        bus.BTN_RAW = 4'b0010;
        tick();
        tick();
        bus.FRAME_STROBE = 1'b1;
        tick();
        check_out("b2b_1", 5'b1_00_00);
        tick();
        check_out("b2b_2", 5'b1_00_00);
        tick();
        bus.FRAME_STROBE = 1'b0;
        check_out("b2b_3", 5'b1_10_00);
        tick();
        check_out("b2b_end", 5'b0_00_00);
        bus.BTN_RAW = 4'b0000;
        for (int i = 1; i <= 3; i++) strobe($sformatf("b2b_rel%0d", i), 2'b00, 2'b00);

        // 2. BTN[0] bounces 1,0,1,0 and then holds 1. The press lands on strobe 7.
        alt = 7'b1110101;  // bit i-1 is the level for strobe i
        for (int i = 1; i <= 7; i++) begin
            bus.BTN_RAW = {3'b000, alt[i-1]};
            strobe($sformatf("t2_s%0d", i), (i == 7) ? 2'b01 : 2'b00, 2'b00);
        end
        // 6. Release: no event, the level drops on the 3rd low strobe, and no repeats follow.
        bus.BTN_RAW = 4'b0000;
        for (int i = 1; i <= 6; i++) strobe($sformatf("t6_s%0d", i), 2'b00, 2'b00);

        // 3. BTN[2] is held for 50 strobes and then released.
        // The repeat due at strobe 51 still fires because the release is still debouncing.
        bus.BTN_RAW = 4'b0100;
        for (int i = 1; i <= 61; i++) begin
            if (i == 51) bus.BTN_RAW = 4'b0000;
            strobe($sformatf("t3_s%0d", i), 2'b00,
                   (i == 3 || i == 33 || i == 39 || i == 45 || i == 51) ? 2'b01 : 2'b00);
        end

        // 4. Next, prev and dec rise together. The tool pair cancels and the probe pair reports dec.
        bus.BTN_RAW = 4'b1011;
        strobe("t4_s1", 2'b00, 2'b00);
        strobe("t4_s2", 2'b00, 2'b00);
        strobe("t4_s3", 2'b00, 2'b10);
        bus.BTN_RAW = 4'b0000;
        for (int i = 4; i <= 6; i++) strobe($sformatf("t4_s%0d", i), 2'b00, 2'b00);

        // 5. BTN[2] is held, and RESET arrives together with strobe 20.
        bus.BTN_RAW = 4'b0100;
        for (int i = 1; i <= 19; i++)
            strobe($sformatf("t5_pre%0d", i), 2'b00, (i == 3) ? 2'b01 : 2'b00);
        tick();
        tick();
        bus.FRAME_STROBE = 1'b1;
        RESET            = 1'b1;
        tick();
        bus.FRAME_STROBE = 1'b0;
        RESET            = 1'b0;
        check_out("t5_reset", 5'b0_00_00);
        // After reset the press is seen again at +3 and the first repeat at +33.
        for (int i = 1; i <= 33; i++)
            strobe($sformatf("t5_post%0d", i), 2'b00, (i == 3 || i == 33) ? 2'b01 : 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
